// File: rtl/tape_pkg.sv
// tape_pkg: shared types for the Brainfuck data-tape controller.
//
// Contents:
//   TAPE_OP_W    - width of the command opcode field
//   tape_op_e    - command opcodes (codes 6 and 7 are unnamed and act as NOPs)
//   tape_state_e - controller FSM states; CLEAR exists only with TAPE_CLEAR_EN
//   TAPE_RESET_STATE - state entered on reset
//   tape_dbg_t   - debug view of the FSM state and the dirty flag
//
// Configuration macro: TAPE_CLEAR_EN (enables the zero-fill state after reset).
package tape_pkg;

    localparam int TAPE_OP_W = 3;

    typedef enum logic [TAPE_OP_W-1:0] {
        INC   = 3'd0,
        DEC   = 3'd1,
        LEFT  = 3'd2,
        RIGHT = 3'd3,
        SET   = 3'd4,
        FLUSH = 3'd5
    } tape_op_e;

    typedef enum logic [1:0] {
`ifdef TAPE_CLEAR_EN
        CLEAR = 2'd0,
`endif
        RD    = 2'd1,
        RDW   = 2'd2,
        IDLE  = 2'd3
    } tape_state_e;

`ifdef TAPE_CLEAR_EN
    localparam tape_state_e TAPE_RESET_STATE = CLEAR;
`else
    localparam tape_state_e TAPE_RESET_STATE = RD;
`endif

    typedef struct packed {
        tape_state_e state;
        logic        dirty;
    } tape_dbg_t;

endpackage

// File: rtl/tape_ctrl.sv
// tape_ctrl: data-tape controller for the Brainfuck core.
//
// Initiator side of a single-port, synchronous-read RAM holding the tape.
// The current cell is cached in a register so INC/DEC/SET complete in one
// cycle; a modified cell is written back only when the head moves (LEFT /
// RIGHT) or on FLUSH.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cmd_valid/ready   - command handshake from the instruction sequencer
//   cmd_op, cmd_data  - opcode (tape_op_e) and SET operand
//   cell_value        - cached current cell (valid while cmd_ready)
//   cell_zero         - cell_value == 0
//   ptr               - current head position
//   mem_we/addr/wdata - RAM write enable, address, write data
//   mem_rdata         - RAM read data, valid one cycle after its address
//   dbg               - FSM state and dirty flag
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the FSM state (high in
// IDLE), never on cmd_valid; cmd_op/cmd_data are sampled only on transfer.
//
// Configuration macro: TAPE_CLEAR_EN. When defined, reset enters CLEAR which
// zero-fills all 2^ADDR_WIDTH cells and then goes straight to IDLE with a zero
// cell. When undefined, reset fetches mem[0] via RD/RDW.
module tape_ctrl
    import tape_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [TAPE_OP_W-1:0]  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] cell_value,
    output logic                  cell_zero,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output tape_dbg_t             dbg
);

    tape_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] cell_q, cell_d;
    logic                  dirty_q, dirty_d;
`ifdef TAPE_CLEAR_EN
    // One extra bit so reaching 2^ADDR_WIDTH is visible without wrapping.
    logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;
`endif

    tape_op_e op;
    logic     accept;
    logic     is_move;
    logic     write_back;

    assign op      = tape_op_e'(cmd_op);
    assign accept  = cmd_valid && (state_q == IDLE);
    assign is_move = (op == LEFT) || (op == RIGHT);
    // The cached cell is written to its old address in the accept cycle, so
    // it never collides with the read of the new address one cycle later.
    assign write_back = accept && dirty_q && (is_move || (op == FLUSH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TAPE_RESET_STATE;
            ptr_q     <= '0;
            cell_q    <= '0;
            dirty_q   <= 1'b0;
`ifdef TAPE_CLEAR_EN
            clr_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cell_q    <= cell_d;
            dirty_q   <= dirty_d;
`ifdef TAPE_CLEAR_EN
            clr_cnt_q <= clr_cnt_d;
`endif
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cell_d    = cell_q;
        dirty_d   = dirty_q;
`ifdef TAPE_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
`endif
        case (state_q)
`ifdef TAPE_CLEAR_EN
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_d[ADDR_WIDTH]) begin
                    state_d = IDLE;
                end
            end
`endif
            RD: begin
                state_d = RDW;
            end
            RDW: begin
                cell_d  = mem_rdata;
                state_d = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    case (op)
                        INC: begin
                            cell_d  = cell_q + 1'b1;
                            dirty_d = 1'b1;
                        end
                        DEC: begin
                            cell_d  = cell_q - 1'b1;
                            dirty_d = 1'b1;
                        end
                        SET: begin
                            cell_d  = cmd_data;
                            dirty_d = 1'b1;
                        end
                        LEFT: begin
                            ptr_d   = ptr_q - 1'b1;
                            dirty_d = 1'b0;
                            state_d = RD;
                        end
                        RIGHT: begin
                            ptr_d   = ptr_q + 1'b1;
                            dirty_d = 1'b0;
                            state_d = RD;
                        end
                        FLUSH: begin
                            dirty_d = 1'b0;
                        end
                        default: ;  // codes 6/7: accepted, no effect
                    endcase
                end
            end
            default: begin
                state_d = RD;
            end
        endcase
    end

    // RAM-side outputs
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = cell_q;
        case (state_q)
`ifdef TAPE_CLEAR_EN
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q[ADDR_WIDTH-1:0];
                mem_wdata = '0;
            end
`endif
            IDLE: begin
                mem_we = write_back;
            end
            default: ;
        endcase
    end

    assign cmd_ready  = (state_q == IDLE);
    assign cell_value = cell_q;
    assign cell_zero  = (cell_q == '0);
    assign ptr        = ptr_q;
    assign dbg.state  = state_q;
    assign dbg.dirty  = dirty_q;

endmodule
